bsg_cache_sbuf_drain_ctrl: RTL and testbench
============================================

# bsg_cache_sbuf_drain_ctrl

Two-entry store buffer for the cache data path. Stores (address, data, byte mask) enter from the cache pipeline's store stage and drain in order to the data-memory write port. It also gives the load pipeline a combinational byte-level bypass of pending stores. Head (oldest) storage is entry 1 and tail storage is entry 0, so entries advance 0 -> 1, matching the existing sbuf datapath ordering.

## Interface
- data_width_p, 128, store data width in bits; must be a multiple of 8
- addr_width_p, 32, byte address width
- mask_width_lp, data_width_p/8, byte-mask width (derived)
- lg_bytes_lp, log2(mask_width_lp), low address bits ignored in comparisons (derived)

Ports:
- clk_i  in  1  clock; all state changes on the rising edge
- reset_n_i  in  1  reset; asynchronous, active-low
- v_i  in  1  store valid
- addr_i  in  addr_width_p  store byte address
- data_i  in  data_width_p  store data
- mask_i  in  mask_width_lp  store byte enables
- ready_o  out  1  buffer can accept a store this cycle
- v_o  out  1  head entry valid for drain
- addr_o  out  addr_width_p  head address
- data_o  out  data_width_p  head data
- mask_o  out  mask_width_lp  head mask
- yumi_i  in  1  memory consumes head this cycle; legal only when v_o=1
- bypass_addr_i  in  addr_width_p  load lookup address
- bypass_data_o  out  data_width_p  merged pending-store data
- bypass_mask_o  out  mask_width_lp  bytes supplied by pending stores
- empty_o  out  1  num_els==0
- full_o  out  1  num_els==2

## Operation
- State: num_els (0..2), entry 0 {addr, data, mask}, entry 1 {addr, data, mask}. No other FSM.
- enq = v_i & ready_o. deq = yumi_i.
- ready_o = ~full_o. It is a registered-state function with no combinational path from yumi_i.
- v_o = (num_els != 0). Head outputs always show entry 1. There is no fall-through: a store written while empty appears on v_o the next cycle.
- Transitions and entry loads:
  - num_els=0, enq: entry1 <= input; num_els -> 1.
  - num_els=1, enq & ~deq: entry0 <= input; num_els -> 2.
  - num_els=1, enq & deq: entry1 <= input; num_els stays 1.
  - num_els=1, deq & ~enq: num_els -> 0.
  - num_els=2, deq: entry1 <= entry0; num_els -> 1. enq cannot occur because ready_o=0.
  - Otherwise: hold.
- Mask values are stored verbatim. A store with mask_i=0 is still enqueued and drained.
- Bypass (combinational):
  - matchN = validN & (entryN.addr[addr_width_p-1:lg_bytes_lp] == bypass_addr_i[addr_width_p-1:lg_bytes_lp]).
  - Entry 1 is valid when num_els>=1. Entry 0 is valid when num_els==2.
  - bypass_mask_o = (match0 ? mask0 : 0) | (match1 ? mask1 : 0).
  - For each byte b: take entry 0's byte when match0 & mask0[b]; else entry 1's byte when match1 & mask1[b]; else 0. The newer store wins.
  - Bypass reflects registered state only. A store on v_i in the same cycle is not visible.
- Errors: yumi_i while v_o=0 is illegal. The simulation assertion fires and state is unchanged. v_i while ready_o=0 is simply not accepted; the producer must hold the store.

## Timing
- Reset (async assert, sync deassert by the system): num_els=0 and all entry fields 0. So ready_o=1, v_o=0, empty_o=1, full_o=0, and addr_o, data_o, mask_o, bypass_data_o, bypass_mask_o are all 0.
- Reset asserted mid-operation discards all pending stores immediately, with no clock required.
- Enqueue-to-v_o latency: 1 cycle. Dequeue-to-next-head latency: 1 cycle.
- Sustained throughput: 1 store/cycle when the drain yumis every cycle at num_els=1.
- Bypass outputs settle combinationally from state and bypass_addr_i within the same cycle.

## Test plan
- Reset, then a single store addr=0x100, data=all 0xAA, mask=0xFFFF at cycle 0 -> cycle 1: v_o=1, addr_o=0x100, data_o=0xAA.., ready_o=1; yumi at cycle 1 -> cycle 2: empty_o=1.
- Fill: stores A (0x100), then B (0x200), no yumi -> full_o=1 and ready_o=0. A held v_i=1 store C is not taken. yumi -> head B, ready_o=1, then C accepted.
- Steady stream: num_els=1, enq & yumi every cycle for 8 cycles with addr 0x0..0x70 -> num_els stays 1 and drain order equals enqueue order.
- Bypass merge:
  - Stimulus: entry1 {0x300, bytes=0x11, mask=0x00FF}; entry0 {0x308, bytes=0x22, mask=0x0F0F}; lookup 0x30C.
  - Response: bypass_mask_o=0x0FFF. Bytes 0-3 and 8-11 are 0x22. Bytes 4-7 are 0x11. Bytes 12-15 are 0.
- Bypass miss and empty: lookup 0x400 with no matching entry, and lookup with num_els=0 -> bypass_mask_o=0 and bypass_data_o=0.
- Async reset with num_els=2, asserted between clock edges -> v_o=0 and ready_o=1 without waiting for a clock edge. After release, the first store behaves as in scenario 1.

Source files
------------

// File: rtl/bsg_cache_sbuf_drain_ctrl.sv
// Two-entry in-order store buffer between the cache store stage and the
// data-memory write port. The load pipeline gets a byte-level bypass of
// pending stores.
//
// num_els | meaning
// --------+----------------------------------------------
// 0       | empty, both entries idle
// 1       | entry 1 holds the only (head) store
// 2       | entry 1 = head (older), entry 0 = tail (newer)
module bsg_cache_sbuf_drain_ctrl #(
  parameter int data_width_p  = 128,
  parameter int addr_width_p  = 32,
  localparam int mask_width_lp = data_width_p / 8,
  localparam int lg_bytes_lp   = $clog2(mask_width_lp)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     v_i,
  input  logic [addr_width_p-1:0]  addr_i,
  input  logic [data_width_p-1:0]  data_i,
  input  logic [mask_width_lp-1:0] mask_i,
  output logic                     ready_o,
  output logic                     v_o,
  output logic [addr_width_p-1:0]  addr_o,
  output logic [data_width_p-1:0]  data_o,
  output logic [mask_width_lp-1:0] mask_o,
  input  logic                     yumi_i,
  input  logic [addr_width_p-1:0]  bypass_addr_i,
  output logic [data_width_p-1:0]  bypass_data_o,
  output logic [mask_width_lp-1:0] bypass_mask_o,
  output logic                     empty_o,
  output logic                     full_o
);

  logic [1:0]               num_els, num_els_n;
  logic [addr_width_p-1:0]  addr0, addr1;
  logic [data_width_p-1:0]  data0, data1;
  logic [mask_width_lp-1:0] mask0, mask1;

  logic enq, deq;
  logic load1_in, load0_in, shift_0_to_1;
  logic match0, match1;

  // Low address bits only select a byte within the line; the bypass ignores them.
  logic unused_bypass_lsbs;
  assign unused_bypass_lsbs = ^bypass_addr_i[lg_bytes_lp-1:0];

  assign empty_o = (num_els == 2'd0);
  assign full_o  = (num_els == 2'd2);
  assign ready_o = ~full_o;
  assign v_o     = ~empty_o;
  assign addr_o  = addr1;
  assign data_o  = data1;
  assign mask_o  = mask1;

  // An illegal yumi (nothing to drain) is masked so state is left untouched.
  assign enq = v_i & ready_o;
  assign deq = yumi_i & v_o;

  // Occupancy transitions and which entry gets loaded this cycle.
  always_comb begin
    num_els_n    = num_els;
    load1_in     = 1'b0;
    load0_in     = 1'b0;
    shift_0_to_1 = 1'b0;
    case (num_els)
      2'd0: begin
        if (enq) begin
          load1_in  = 1'b1;
          num_els_n = 2'd1;
        end
      end
      2'd1: begin
        if (enq && deq) begin
          load1_in = 1'b1;
        end else if (enq) begin
          load0_in  = 1'b1;
          num_els_n = 2'd2;
        end else if (deq) begin
          num_els_n = 2'd0;
        end
      end
      2'd2: begin
        if (deq) begin
          shift_0_to_1 = 1'b1;
          num_els_n    = 2'd1;
        end
      end
      default: num_els_n = 2'd0;
    endcase
  end

  // Occupancy and entry storage; reset wipes pending stores without a clock.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      num_els <= 2'd0;
      addr0   <= '0;
      data0   <= '0;
      mask0   <= '0;
      addr1   <= '0;
      data1   <= '0;
      mask1   <= '0;
    end else begin
      num_els <= num_els_n;
      if (load0_in) begin
        addr0 <= addr_i;
        data0 <= data_i;
        mask0 <= mask_i;
      end
      if (load1_in) begin
        addr1 <= addr_i;
        data1 <= data_i;
        mask1 <= mask_i;
      end else if (shift_0_to_1) begin
        addr1 <= addr0;
        data1 <= data0;
        mask1 <= mask0;
      end
    end
  end

  assign match1 = (num_els != 2'd0) &&
                  (addr1[addr_width_p-1:lg_bytes_lp] == bypass_addr_i[addr_width_p-1:lg_bytes_lp]);
  assign match0 = (num_els == 2'd2) &&
                  (addr0[addr_width_p-1:lg_bytes_lp] == bypass_addr_i[addr_width_p-1:lg_bytes_lp]);

  // Byte-wise merge of pending stores; the newer entry 0 overrides entry 1.
  always_comb begin
    bypass_data_o = '0;
    bypass_mask_o = (match0 ? mask0 : '0) | (match1 ? mask1 : '0);
    for (int b = 0; b < mask_width_lp; b++) begin
      if (match0 && mask0[b]) begin
        bypass_data_o[b*8 +: 8] = data0[b*8 +: 8];
      end else if (match1 && mask1[b]) begin
        bypass_data_o[b*8 +: 8] = data1[b*8 +: 8];
      end
    end
  end

  // The drain side must never yumi an empty buffer.
  a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_bsg_cache_sbuf_drain_ctrl.sv
// Directed bench for the two-entry store buffer: a vector table plus
// hand-written sequences for streaming and asynchronous reset.
module tb_bsg_cache_sbuf_drain_ctrl;

  logic         clk;
  logic         reset_n;
  logic         v_in;
  logic [31:0]  addr_in;
  logic [127:0] data_in;
  logic [15:0]  mask_in;
  logic         ready;
  logic         v_out;
  logic [31:0]  addr_out;
  logic [127:0] data_out;
  logic [15:0]  mask_out;
  logic         yumi;
  logic [31:0]  bp_addr;
  logic [127:0] bp_data;
  logic [15:0]  bp_mask;
  logic         empty;
  logic         full;

  int checks;
  int failures;

  bsg_cache_sbuf_drain_ctrl dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .v_i           (v_in),
    .addr_i        (addr_in),
    .data_i        (data_in),
    .mask_i        (mask_in),
    .ready_o       (ready),
    .v_o           (v_out),
    .addr_o        (addr_out),
    .data_o        (data_out),
    .mask_o        (mask_out),
    .yumi_i        (yumi),
    .bypass_addr_i (bp_addr),
    .bypass_data_o (bp_data),
    .bypass_mask_o (bp_mask),
    .empty_o       (empty),
    .full_o        (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [31:0]  addr;
    logic [127:0] data;
    logic [15:0]  mask;
    logic         yumi;
    logic [31:0]  bp;
    logic         e_ready;
    logic         e_v;
    logic         chk_head;
    logic [31:0]  e_addr;
    logic [127:0] e_data;
    logic [15:0]  e_mask;
    logic         e_empty;
    logic         e_full;
    logic [15:0]  e_bmask;
    logic [127:0] e_bdata;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    v_in = 1'b0; addr_in = '0; data_in = '0; mask_in = '0; yumi = 1'b0; bp_addr = '0;
  endtask

  // Drive at the negedge, check settled outputs, let the next posedge act on the inputs.
  task automatic drive(input logic v, input logic [31:0] a, input logic [127:0] d,
                       input logic [15:0] m, input logic y, input logic [31:0] bp);
    @(negedge clk);
    v_in = v; addr_in = a; data_in = d; mask_in = m; yumi = y; bp_addr = bp;
    #1;
  endtask

  task automatic first_store_seq(input string tag);
    drive(1'b1, 32'h100, {16{8'hAA}}, 16'hFFFF, 1'b0, 32'h0);
    chk({tag, "_pre_empty"}, 128'(empty), 128'd1);
    drive(1'b0, 32'h0, '0, '0, 1'b1, 32'h0);
    chk({tag, "_v"}, 128'(v_out), 128'd1);
    chk({tag, "_addr"}, 128'(addr_out), 128'h100);
    chk({tag, "_data"}, data_out, {16{8'hAA}});
    chk({tag, "_ready"}, 128'(ready), 128'd1);
    drive(1'b0, 32'h0, '0, '0, 1'b0, 32'h0);
    chk({tag, "_drained_empty"}, 128'(empty), 128'd1);
  endtask

  logic [31:0] q[$];
  logic [31:0] exp_head;

  initial begin
    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    idle_inputs();

    // v | addr | data | mask | yumi | bp | ready v chk_head | addr data mask | empty full | bmask bdata
    vecs[0]  = '{0, 32'h0,   '0,           16'h0,    0, 32'h0,   1,0,1, 32'h0,   '0,           16'h0,    1,0, 16'h0,    '0};
    vecs[1]  = '{1, 32'h100, {16{8'hAA}},  16'hFFFF, 0, 32'h100, 1,0,0, 32'h0,   '0,           16'h0,    1,0, 16'h0,    '0};
    vecs[2]  = '{0, 32'h0,   '0,           16'h0,    1, 32'h100, 1,1,1, 32'h100, {16{8'hAA}},  16'hFFFF, 0,0, 16'hFFFF, {16{8'hAA}}};
    vecs[3]  = '{0, 32'h0,   '0,           16'h0,    0, 32'h100, 1,0,0, 32'h0,   '0,           16'h0,    1,0, 16'h0,    '0};
    vecs[4]  = '{1, 32'h100, {16{8'h01}},  16'hFFFF, 0, 32'h0,   1,0,0, 32'h0,   '0,           16'h0,    1,0, 16'h0,    '0};
    vecs[5]  = '{1, 32'h200, {16{8'h02}},  16'h00FF, 0, 32'h0,   1,1,1, 32'h100, {16{8'h01}},  16'hFFFF, 0,0, 16'h0,    '0};
    vecs[6]  = '{1, 32'h300, {16{8'h03}},  16'h000F, 0, 32'h200, 0,1,1, 32'h100, {16{8'h01}},  16'hFFFF, 0,1, 16'h00FF, {64'h0, {8{8'h02}}}};
    vecs[7]  = '{1, 32'h300, {16{8'h03}},  16'h000F, 1, 32'h0,   0,1,1, 32'h100, {16{8'h01}},  16'hFFFF, 0,1, 16'h0,    '0};
    vecs[8]  = '{1, 32'h300, {16{8'h03}},  16'h000F, 0, 32'h0,   1,1,1, 32'h200, {16{8'h02}},  16'h00FF, 0,0, 16'h0,    '0};
    vecs[9]  = '{0, 32'h0,   '0,           16'h0,    1, 32'h300, 0,1,1, 32'h200, {16{8'h02}},  16'h00FF, 0,1, 16'h000F, {96'h0, {4{8'h03}}}};
    vecs[10] = '{0, 32'h0,   '0,           16'h0,    1, 32'h0,   1,1,1, 32'h300, {16{8'h03}},  16'h000F, 0,0, 16'h0,    '0};
    vecs[11] = '{0, 32'h0,   '0,           16'h0,    0, 32'h0,   1,0,0, 32'h0,   '0,           16'h0,    1,0, 16'h0,    '0};
    vecs[12] = '{1, 32'h300, {16{8'h11}},  16'h00FF, 0, 32'h0,   1,0,0, 32'h0,   '0,           16'h0,    1,0, 16'h0,    '0};
    vecs[13] = '{1, 32'h308, {16{8'h22}},  16'h0F0F, 0, 32'h0,   1,1,1, 32'h300, {16{8'h11}},  16'h00FF, 0,0, 16'h0,    '0};
    vecs[14] = '{0, 32'h0,   '0,           16'h0,    0, 32'h30C, 0,1,1, 32'h300, {16{8'h11}},  16'h00FF, 0,1, 16'h0FFF, 128'h00000000_22222222_11111111_22222222};
    vecs[15] = '{0, 32'h0,   '0,           16'h0,    0, 32'h400, 0,1,1, 32'h300, {16{8'h11}},  16'h00FF, 0,1, 16'h0,    '0};
    vecs[16] = '{0, 32'h0,   '0,           16'h0,    1, 32'h30C, 0,1,1, 32'h300, {16{8'h11}},  16'h00FF, 0,1, 16'h0FFF, 128'h00000000_22222222_11111111_22222222};
    vecs[17] = '{0, 32'h0,   '0,           16'h0,    1, 32'h30C, 1,1,1, 32'h308, {16{8'h22}},  16'h0F0F, 0,0, 16'h0F0F, 128'h00000000_22222222_00000000_22222222};
    vecs[18] = '{0, 32'h0,   '0,           16'h0,    0, 32'h30C, 1,0,0, 32'h0,   '0,           16'h0,    1,0, 16'h0,    '0};

    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].v, vecs[i].addr, vecs[i].data, vecs[i].mask, vecs[i].yumi, vecs[i].bp);
      chk($sformatf("v%0d_ready", i), 128'(ready), 128'(vecs[i].e_ready));
      chk($sformatf("v%0d_v", i), 128'(v_out), 128'(vecs[i].e_v));
      chk($sformatf("v%0d_empty", i), 128'(empty), 128'(vecs[i].e_empty));
      chk($sformatf("v%0d_full", i), 128'(full), 128'(vecs[i].e_full));
      chk($sformatf("v%0d_bmask", i), 128'(bp_mask), 128'(vecs[i].e_bmask));
      chk($sformatf("v%0d_bdata", i), bp_data, vecs[i].e_bdata);
      if (vecs[i].chk_head) begin
        chk($sformatf("v%0d_addr", i), 128'(addr_out), 128'(vecs[i].e_addr));
        chk($sformatf("v%0d_data", i), data_out, vecs[i].e_data);
        chk($sformatf("v%0d_mask", i), 128'(mask_out), 128'(vecs[i].e_mask));
      end
    end

    // Steady stream: one store in, one store out each cycle at num_els=1.
    drive(1'b1, 32'h0, 128'h0, 16'hFFFF, 1'b0, 32'h0);
    q.push_back(32'h0);
    for (int i = 1; i < 8; i++) begin
      drive(1'b1, 32'(i * 16), 128'(i), 16'hFFFF, 1'b1, 32'h0);
      exp_head = q.pop_front();
      q.push_back(32'(i * 16));
      chk($sformatf("stream%0d_head", i), 128'(addr_out), 128'(exp_head));
      chk($sformatf("stream%0d_v", i), 128'(v_out), 128'd1);
      chk($sformatf("stream%0d_full", i), 128'(full), 128'd0);
      chk($sformatf("stream%0d_ready", i), 128'(ready), 128'd1);
    end
    drive(1'b0, 32'h0, '0, '0, 1'b1, 32'h0);
    exp_head = q.pop_front();
    chk("stream_last_head", 128'(addr_out), 128'(exp_head));
    drive(1'b0, 32'h0, '0, '0, 1'b0, 32'h0);
    chk("stream_end_empty", 128'(empty), 128'd1);

    // Async reset with two entries pending, asserted away from any clock edge.
    drive(1'b1, 32'h500, {16{8'h55}}, 16'hFFFF, 1'b0, 32'h0);
    drive(1'b1, 32'h600, {16{8'h66}}, 16'hFFFF, 1'b0, 32'h0);
    drive(1'b0, 32'h0, '0, '0, 1'b0, 32'h500);
    chk("pre_rst_full", 128'(full), 128'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_rst_v", 128'(v_out), 128'd0);
    chk("async_rst_ready", 128'(ready), 128'd1);
    chk("async_rst_empty", 128'(empty), 128'd1);
    chk("async_rst_full", 128'(full), 128'd0);
    chk("async_rst_addr", 128'(addr_out), 128'd0);
    chk("async_rst_data", data_out, 128'd0);
    chk("async_rst_mask", 128'(mask_out), 128'd0);
    chk("async_rst_bmask", 128'(bp_mask), 128'd0);
    chk("async_rst_bdata", bp_data, 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    first_store_seq("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
